trail_arbiter: RTL and testbench



---
 rtl/trail_pkg.sv | 22 ++
 rtl/trail_clear_sweep.sv | 34 +++
 rtl/trail_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_trail_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trail_pkg.sv
// Shared types and colour helpers for the trail arbiter.
package trail_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_READ   = 3'd2,
        ST_DECIDE = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Colours are kept as int and sized at the point of use, so the same
    // constants serve any framebuffer width (crash = all ones after sizing).
    localparam int COLOR_EMPTY = 0;
    localparam int COLOR_CRASH = -1;

    function automatic int player_color(input int idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/trail_clear_sweep.sv
// Address counter that walks the whole framebuffer once per start pulse.
module trail_clear_sweep #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              busy_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;

    // Counter runs from 0 to all ones, then wraps back to 0 and stops.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            addr_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (last_o) busy_q <= 1'b0;
        end
    end

    assign addr_o = addr_q;
    assign busy_o = busy_q;
    assign last_o = busy_q && (&addr_q);

endmodule

// File: rtl/trail_arbiter.sv
// Per-tick framebuffer arbiter: reads each head cell, decides crashes,
// writes trail/crash colours, and wipes the playfield on request.
// Build option: define TRAIL_BOUNDS_EN to kill players whose head leaves
// the X_MAX x Y_MAX field (their write slot is then suppressed).
//
// state  | meaning
// IDLE   | wait for clear_req or a rising clonke edge
// CLEAR  | write 0 to every address, then revive everyone
// READ   | issue one read per player, capture data RAM_LAT cycles later
// DECIDE | resolve occupied cells, head-on collisions and bounds
// WRITE  | one write slot per player, index order
// DONE   | one-cycle done pulse, refresh round_over/winner
module trail_arbiter
    import trail_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COLOR_W     = 3,
    parameter int RAM_LAT     = 1,
    parameter int X_MAX       = 160,
    parameter int Y_MAX       = 120
) (
    input  logic                               CLOCK_50,
    input  logic                               reset,
    input  logic                               clonke,
    input  logic                               clear_req,
    input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]   pos_in,
    output logic [X_W+Y_W-1:0]                 ram_addr,
    output logic                               ram_wren,
    output logic [COLOR_W-1:0]                 ram_wdata,
    input  logic [COLOR_W-1:0]                 ram_q,
    output logic [NUM_PLAYERS-1:0]             alive,
    output logic                               busy,
    output logic                               done,
    output logic                               round_over,
    output logic [$clog2(NUM_PLAYERS)-1:0]     winner,
    output logic                               tick_overrun
);

    localparam int XY_W   = X_W + Y_W;
    localparam int WIN_W  = $clog2(NUM_PLAYERS);
    localparam int CNT_W  = $clog2(NUM_PLAYERS + RAM_LAT + 1);
    localparam int ACNT_W = $clog2(NUM_PLAYERS + 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     clonke_q;
    logic [XY_W-1:0]          snap_q [NUM_PLAYERS];
    logic [COLOR_W-1:0]       cell_q [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]   alive_q, live_pre_q, oob_q;
    logic                     round_over_q, tick_overrun_q;
    logic [WIN_W-1:0]         winner_q;

    logic                     tick_edge;
    logic                     sweep_start, sweep_busy, sweep_last;
    logic [XY_W-1:0]          sweep_addr;
    logic [NUM_PLAYERS-1:0]   oob, head_hit, die;
    logic [ACNT_W-1:0]        alive_cnt;
    logic [WIN_W-1:0]         sole_idx;

    assign tick_edge = clonke & ~clonke_q;

    trail_clear_sweep #(.ADDR_W(XY_W)) u_sweep (
        .clk     (CLOCK_50),
        .reset   (reset),
        .start_i (sweep_start),
        .addr_o  (sweep_addr),
        .busy_o  (sweep_busy),
        .last_o  (sweep_last)
    );

    // Next-state logic; clear_req beats a tick edge arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        sweep_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d     = ST_CLEAR;
                    sweep_start = 1'b1;
                end else if (tick_edge) begin
                    state_d = ST_READ;
                end
            end
            ST_CLEAR:  if (sweep_last) state_d = ST_DONE;
            ST_READ:   if (cnt_q == CNT_W'(NUM_PLAYERS + RAM_LAT - 1)) state_d = ST_DECIDE;
            ST_DECIDE: state_d = ST_WRITE;
            ST_WRITE:  if (cnt_q == CNT_W'(NUM_PLAYERS - 1)) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Crash decision: occupied cell, shared head with another live player, or off-field.
    always_comb begin
        oob      = '0;
        head_hit = '0;
        die      = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
`ifdef TRAIL_BOUNDS_EN
            oob[i] = (int'(snap_q[i][XY_W-1:Y_W]) >= X_MAX) || (int'(snap_q[i][Y_W-1:0]) >= Y_MAX);
`endif
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (j != i && alive_q[j] && snap_q[j] == snap_q[i]) head_hit[i] = 1'b1;
            end
            die[i] = alive_q[i] && ((cell_q[i] != COLOR_W'(COLOR_EMPTY)) || head_hit[i] || oob[i]);
        end
    end

    // Survivor count and index of the highest live player (the sole one when count is 1).
    always_comb begin
        alive_cnt = '0;
        sole_idx  = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive_q[i]) begin
                alive_cnt = alive_cnt + ACNT_W'(1);
                sole_idx  = WIN_W'(i);
            end
        end
    end

    // RAM port drive; idle states leave the bus at zero.
    always_comb begin
        ram_addr  = '0;
        ram_wren  = 1'b0;
        ram_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                ram_addr = sweep_addr;
                ram_wren = sweep_busy;
            end
            ST_READ: begin
                for (int i = 0; i < NUM_PLAYERS; i++)
                    if (cnt_q == CNT_W'(i)) ram_addr = snap_q[i];
            end
            ST_WRITE: begin
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (cnt_q == CNT_W'(i) && live_pre_q[i] && !oob_q[i]) begin
                        ram_wren  = 1'b1;
                        ram_addr  = snap_q[i];
                        ram_wdata = alive_q[i] ? COLOR_W'(player_color(i)) : COLOR_W'(COLOR_CRASH);
                    end
                end
            end
            default: ;
        endcase
    end

    // Sequential state: FSM, snapshots, captured cells, alive flags and status.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            clonke_q       <= 1'b0;
            alive_q        <= '1;
            live_pre_q     <= '0;
            oob_q          <= '0;
            round_over_q   <= 1'b0;
            winner_q       <= '0;
            tick_overrun_q <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                snap_q[i] <= '0;
                cell_q[i] <= '0;
            end
        end else begin
            clonke_q <= clonke;
            state_q  <= state_d;
            if (tick_edge && state_q != ST_IDLE) tick_overrun_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!clear_req && tick_edge)
                        for (int i = 0; i < NUM_PLAYERS; i++)
                            snap_q[i] <= pos_in[i*XY_W +: XY_W];
                end
                ST_CLEAR: begin
                    if (sweep_last) begin
                        alive_q        <= '1;
                        tick_overrun_q <= 1'b0;
                        round_over_q   <= 1'b0;
                    end
                end
                ST_READ: begin
                    cnt_q <= (state_d == ST_DECIDE) ? '0 : cnt_q + CNT_W'(1);
                    for (int i = 0; i < NUM_PLAYERS; i++)
                        if (cnt_q == CNT_W'(i + RAM_LAT)) cell_q[i] <= ram_q;
                end
                ST_DECIDE: begin
                    live_pre_q <= alive_q;
                    oob_q      <= oob;
                    alive_q    <= alive_q & ~die;
                    cnt_q      <= '0;
                end
                ST_WRITE: cnt_q <= cnt_q + CNT_W'(1);
                ST_DONE: begin
                    round_over_q <= (alive_cnt <= ACNT_W'(1));
                    winner_q     <= (alive_cnt == ACNT_W'(1)) ? sole_idx : '0;
                end
                default: ;
            endcase
        end
    end

    assign alive        = alive_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign round_over   = round_over_q;
    assign winner       = winner_q;
    assign tick_overrun = tick_overrun_q;

endmodule

// File: tb/tb_trail_arbiter.sv
module tb_trail_arbiter;
    localparam int N  = 4;
    localparam int AW = 15;
    localparam int CW = 3;

    logic            CLOCK_50 = 1'b0;
    logic            reset = 1'b1;
    logic            clonke = 1'b0;
    logic            clear_req = 1'b0;
    logic [N*AW-1:0] pos_in = '0;
    logic [AW-1:0]   ram_addr;
    logic            ram_wren;
    logic [CW-1:0]   ram_wdata;
    logic [CW-1:0]   ram_q = '0;
    logic [N-1:0]    alive;
    logic            busy, done, round_over, tick_overrun;
    logic [1:0]      winner;

    trail_arbiter dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .clonke(clonke), .clear_req(clear_req),
        .pos_in(pos_in), .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
        .ram_q(ram_q), .alive(alive), .busy(busy), .done(done), .round_over(round_over),
        .winner(winner), .tick_overrun(tick_overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Framebuffer RAM with one cycle of read latency
    logic [CW-1:0] mem [1<<AW];
    always @(posedge CLOCK_50) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t wlog[$];
    wr_t exp_w[$];
    always @(negedge CLOCK_50)
        if (ram_wren) wlog.push_back(wr_t'{int'(ram_addr), int'(ram_wdata), cyc});

    int n_pass = 0, n_total = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: framebuffer contents, alive set, current heads
    bit [2:0] ref_mem [1<<AW];
    bit [N-1:0] m_alive = '1;
    int cur_x [N];
    int cur_y [N];

    function automatic int n_alive();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_alive[i]);
        return c;
    endfunction

    function automatic int m_winner();
        int w = 0;
        if (n_alive() == 1)
            for (int i = 0; i < N; i++) if (m_alive[i]) w = i;
        return w;
    endfunction

    task automatic model_tick();
        int  occ[int];
        int  a[N];
        bit  dies[N];
        bit  oob[N];
        exp_w.delete();
        for (int i = 0; i < N; i++) begin
            a[i] = cur_x[i] * 128 + cur_y[i];
            oob[i] = 1'b0;
`ifdef TRAIL_BOUNDS_EN
            oob[i] = (cur_x[i] >= 160) || (cur_y[i] >= 120);
`endif
            if (m_alive[i]) begin
                if (occ.exists(a[i])) occ[a[i]] = occ[a[i]] + 1;
                else occ[a[i]] = 1;
            end
        end
        for (int i = 0; i < N; i++)
            dies[i] = m_alive[i] && (ref_mem[a[i]] != 0 || occ[a[i]] > 1 || oob[i]);
        for (int i = 0; i < N; i++)
            if (m_alive[i] && !oob[i]) exp_w.push_back(wr_t'{a[i], dies[i] ? 7 : i + 1, 0});
        foreach (exp_w[k]) ref_mem[exp_w[k].addr] = 3'(exp_w[k].data);
        for (int i = 0; i < N; i++) if (dies[i]) m_alive[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        m_alive = '1;
    endtask

    // mode 1 adds a second clonke edge and a clear_req while busy
    task automatic do_tick(input string tag, input int mode, output int t0);
        int dcyc;
        @(negedge CLOCK_50);
        for (int i = 0; i < N; i++) pos_in[i*AW +: AW] = AW'(cur_x[i] * 128 + cur_y[i]);
        wlog.delete();
        clonke = 1'b1;
        t0 = cyc;
        @(negedge CLOCK_50);
        clonke = 1'b0;
        dcyc = -1;
        for (int k = 0; k < 60; k++) begin
            if (mode == 1) begin
                clonke    = (cyc - t0 == 3);
                clear_req = (cyc - t0 == 5);
            end
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(negedge CLOCK_50);
        end
        clonke = 1'b0;
        clear_req = 1'b0;
        if (dcyc < 0) chk({tag, "_done_seen"}, 0, 1);
        else chk({tag, "_done_lat"}, dcyc - t0, 11);
        @(negedge CLOCK_50);
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, wlog.size(), exp_w.size());
        for (int k = 0; k < exp_w.size() && k < wlog.size(); k++) begin
            chk({tag, "_wr_addr"}, wlog[k].addr, exp_w[k].addr);
            chk({tag, "_wr_data"}, wlog[k].data, exp_w[k].data);
        end
    endtask

    task automatic chk_state(input string tag, input int ea, input int ero, input int ew);
        chk({tag, "_alive"}, int'(alive), ea);
        chk({tag, "_round_over"}, int'(round_over), ero);
        chk({tag, "_winner"}, int'(winner), ew);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    typedef struct {
        bit rst; bit pk; int pk_x; int pk_y; int pk_v;
        int x0; int y0; int x1; int y1; int x2; int y2; int x3; int y3;
        int ea; int ero; int ew;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit pk, input int px, input int py, input int pv,
                                input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2, input int x3, input int y3,
                                input int ea, input int ero, input int ew);
        vec_t v;
        v.rst = rst; v.pk = pk; v.pk_x = px; v.pk_y = py; v.pk_v = pv;
        v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2; v.x3 = x3; v.y3 = y3;
        v.ea = ea; v.ero = ero; v.ew = ew;
        return v;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int t0, dcyc, errs, nz, extra;
        string tag;

        tbl[0] = mk(0, 0, 0, 0, 0, 10, 5, 20, 5, 30, 5, 40, 5, 4'b1111, 0, 0);
        tbl[1] = mk(0, 0, 0, 0, 0, 50, 50, 50, 50, 60, 60, 70, 70, 4'b1100, 0, 0);
        tbl[2] = mk(0, 1, 80, 80, 2, 50, 50, 50, 50, 80, 80, 90, 90, 4'b1000, 1, 3);
`ifdef TRAIL_BOUNDS_EN
        tbl[3] = mk(1, 0, 0, 0, 0, 165, 10, 100, 10, 101, 10, 102, 10, 4'b1110, 0, 0);
`else
        tbl[3] = mk(1, 0, 0, 0, 0, 165, 10, 100, 10, 101, 10, 102, 10, 4'b1111, 0, 0);
`endif
        tbl[4] = mk(0, 0, 0, 0, 0, 120, 20, 120, 20, 120, 20, 120, 20, 4'b0000, 1, 0);

        for (int a = 0; a < (1 << AW); a++) begin
            mem[a] = '0;
            ref_mem[a] = '0;
        end

        // Reset values
        repeat (3) @(negedge CLOCK_50);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_alive", int'(alive), 4'b1111);
        chk("rst_wren", int'(ram_wren), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_wdata", int'(ram_wdata), 0);
        chk("rst_round_over", int'(round_over), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_overrun", int'(tick_overrun), 0);
        reset = 1'b0;

        // Clear, with a tick edge in the same cycle that must be dropped silently
        @(negedge CLOCK_50);
        wlog.delete();
        clonke = 1'b1;
        clear_req = 1'b1;
        t0 = cyc;
        @(negedge CLOCK_50);
        clonke = 1'b0;
        clear_req = 1'b0;
        chk("clr_busy", int'(busy), 1);
        chk("clr_first_wren", int'(ram_wren), 1);
        chk("clr_first_addr", int'(ram_addr), 0);
        dcyc = -1;
        for (int k = 0; k < 40000; k++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(negedge CLOCK_50);
        end
        if (dcyc < 0) chk("clr_done_seen", 0, 1);
        else chk("clr_done_lat", dcyc - t0, 32769);
        chk("clr_nwr", wlog.size(), 32768);
        errs = 0;
        nz = 0;
        foreach (wlog[k]) begin
            if (wlog[k].addr != k) errs++;
            if (wlog[k].data != 0) nz++;
        end
        chk("clr_addr_seq_errs", errs, 0);
        chk("clr_nonzero_data", nz, 0);
        @(negedge CLOCK_50);
        chk_state("clr", 4'b1111, 0, 0);
        chk("clr_overrun", int'(tick_overrun), 0);
        m_alive = '1;

        // Directed ticks
        for (int v = 0; v < 5; v++) begin
            tag = $sformatf("v%0d", v);
            if (tbl[v].rst) do_reset();
            if (tbl[v].pk) begin
                mem[tbl[v].pk_x * 128 + tbl[v].pk_y] = 3'(tbl[v].pk_v);
                ref_mem[tbl[v].pk_x * 128 + tbl[v].pk_y] = 3'(tbl[v].pk_v);
            end
            cur_x[0] = tbl[v].x0; cur_y[0] = tbl[v].y0;
            cur_x[1] = tbl[v].x1; cur_y[1] = tbl[v].y1;
            cur_x[2] = tbl[v].x2; cur_y[2] = tbl[v].y2;
            cur_x[3] = tbl[v].x3; cur_y[3] = tbl[v].y3;
            model_tick();
            do_tick(tag, 0, t0);
            chk_state(tag, tbl[v].ea, tbl[v].ero, tbl[v].ew);
            chk_writes(tag);
            if (v == 0)
                for (int k = 0; k < wlog.size(); k++) chk("v0_wr_cyc", wlog[k].cyc - t0, 7 + k);
        end

        // Overrun edge and ignored clear_req while busy
        do_reset();
        for (int i = 0; i < N; i++) begin
            cur_x[i] = 10 * (i + 1);
            cur_y[i] = 100;
        end
        model_tick();
        do_tick("ovr", 1, t0);
        chk_state("ovr", 4'b1111, 0, 0);
        chk_writes("ovr");
        chk("ovr_flag", int'(tick_overrun), 1);
        extra = 0;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (busy || done) extra++;
        end
        chk("ovr_no_extra_pass", extra, 0);
        chk("ovr_flag_sticky", int'(tick_overrun), 1);

        // Reset in the middle of the write phase
        @(negedge CLOCK_50);
        pos_in = {AW'(7 * 128 + 110), AW'(6 * 128 + 110), AW'(5 * 128 + 110), AW'(5 * 128 + 110)};
        clonke = 1'b1;
        t0 = cyc;
        @(negedge CLOCK_50);
        clonke = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (cyc - t0 >= 8) break;
            @(negedge CLOCK_50);
        end
        chk("abort_cycle", cyc - t0, 8);
        chk("abort_busy_before", int'(busy), 1);
        chk("abort_alive_decided", int'(alive), 4'b1100);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("abort_busy_after", int'(busy), 0);
        chk("abort_alive_after", int'(alive), 4'b1111);
        chk("abort_overrun_after", int'(tick_overrun), 0);
        chk("abort_wren_after", int'(ram_wren), 0);
        reset = 1'b0;
        m_alive = '1;

        // Randomised ticks against the reference model
        for (int r = 0; r < 80; r++) begin
            if (n_alive() <= 1) do_reset();
            for (int i = 0; i < N; i++) begin
                cur_x[i] = ($urandom_range(0, 9) == 0) ? 160 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
                cur_y[i] = int'($urandom_range(0, 15));
            end
            model_tick();
            do_tick("rnd", 0, t0);
            chk_state("rnd", int'(m_alive), (n_alive() <= 1) ? 1 : 0, m_winner());
            chk_writes("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
